// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: aggregates the UART per-cause interrupt lines into one
// registered CPU interrupt with claim/complete handshake and holdoff timer.
module uart_irq_ctrl #(
  parameter int NUM_SRC       = 8,
  parameter int ID_WIDTH      = $clog2(NUM_SRC),
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC-1:0]       src_i,
  input  logic [NUM_SRC-1:0]       cfg_edge_i,
  input  logic [NUM_SRC-1:0]       cfg_en_i,
  input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff_i,
  input  logic                     claim_valid_i,
  output logic                     claim_ready_o,
  output logic [ID_WIDTH-1:0]      claim_id_o,
  input  logic                     complete_valid_i,
  input  logic [ID_WIDTH-1:0]      complete_id_i,
  output logic                     irq_o,
  output logic [NUM_SRC-1:0]       pending_o,
  output logic                     active_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_CLAIMED,
    S_HOLDOFF
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_SRC-1:0]         src_q;
  logic [NUM_SRC-1:0]         pending_q, pending_d;
  logic [HOLDOFF_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]        claimed_id_q, claimed_id_d;
  logic                       irq_q, active_q;
  logic [NUM_SRC-1:0]         eff;
  logic                       any_eff;
  logic [ID_WIDTH-1:0]        win;
  logic                       claim_fire;

  assign eff           = pending_q & cfg_en_i;
  assign any_eff       = |eff;
  assign claim_ready_o = (state_q == S_ASSERT) && any_eff;
  assign claim_id_o    = claim_ready_o ? win : '0;
  assign claim_fire    = claim_ready_o && claim_valid_i;

  assign irq_o     = irq_q;
  assign active_o  = active_q;
  assign pending_o = pending_q;

  // Fixed priority: scanning downward leaves the lowest set index as winner.
  always_comb begin
    win = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eff[i-1]) win = ID_WIDTH'(i - 1);
    end
  end

  // Pending update: edge bits set on rising edge (set beats claim-clear), level bits track input.
  always_comb begin
    pending_d = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (cfg_edge_i[i]) begin
        pending_d[i] = (src_i[i] & ~src_q[i]) |
                       (pending_q[i] & ~(claim_fire && (win == ID_WIDTH'(i))));
      end else begin
        pending_d[i] = src_i[i];
      end
    end
  end

  // Next-state logic for the claim/complete/holdoff sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    claimed_id_d = claimed_id_q;
    case (state_q)
      S_IDLE: begin
        if (any_eff) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (claim_fire) begin
          claimed_id_d = win;
          state_d      = S_CLAIMED;
        end else if (!any_eff) begin
          state_d = S_IDLE;
        end
      end
      S_CLAIMED: begin
        if (complete_valid_i && (complete_id_i == claimed_id_q)) begin
          if (cfg_holdoff_i == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cfg_holdoff_i;
            state_d = S_HOLDOFF;
          end
        end
      end
      S_HOLDOFF: begin
        // Counter is never loaded with zero, so it stops at 1 and never wraps.
        if (cnt_q <= HOLDOFF_WIDTH'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - HOLDOFF_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, sampling and registered-output flops with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      pending_q    <= '0;
      cnt_q        <= '0;
      claimed_id_q <= '0;
      irq_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_i;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      claimed_id_q <= claimed_id_d;
      irq_q        <= (state_d == S_ASSERT);
      active_q     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed self-checking bench for uart_irq_ctrl.
module tb_uart_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic [7:0]  cfg_edge;
  logic [7:0]  cfg_en;
  logic [15:0] cfg_holdoff;
  logic        claim_valid;
  logic        claim_ready;
  logic [2:0]  claim_id;
  logic        complete_valid;
  logic [2:0]  complete_id;
  logic        irq;
  logic [7:0]  pending;
  logic        active;

  int unsigned total = 0;
  int unsigned bad   = 0;

  uart_irq_ctrl #(
    .NUM_SRC(8),
    .ID_WIDTH(3),
    .HOLDOFF_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .src_i(src),
    .cfg_edge_i(cfg_edge),
    .cfg_en_i(cfg_en),
    .cfg_holdoff_i(cfg_holdoff),
    .claim_valid_i(claim_valid),
    .claim_ready_o(claim_ready),
    .claim_id_o(claim_id),
    .complete_valid_i(complete_valid),
    .complete_id_i(complete_id),
    .irq_o(irq),
    .pending_o(pending),
    .active_o(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic claim_once();
    claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
  endtask

  task automatic complete_once(input logic [2:0] id);
    complete_valid = 1'b1;
    complete_id    = id;
    step();
    complete_valid = 1'b0;
    complete_id    = '0;
  endtask

  initial begin
    rst = 1'b1; src = '0; cfg_edge = 8'hFF; cfg_en = 8'hFF; cfg_holdoff = '0;
    claim_valid = 1'b0; complete_valid = 1'b0; complete_id = '0;

    // Reset state
    step(); step();
    check("rst_irq", irq, 0);
    check("rst_ready", claim_ready, 0);
    check("rst_id", claim_id, 0);
    check("rst_pending", pending, 0);
    check("rst_active", active, 0);
    rst = 1'b0;
    step(); step();

    // Single edge on source 4, H = 0
    src = 8'h10; step(); src = '0;
    check("t1_pend", pending, 8'h10);
    check("t1_irq_n1", irq, 0);
    step();
    check("t1_irq", irq, 1);
    check("t1_id", claim_id, 4);
    check("t1_ready", claim_ready, 1);
    claim_once();
    check("t1_claim_irq", irq, 0);
    check("t1_claim_pend", pending, 0);
    check("t1_claimed_active", active, 1);
    complete_once(3'd4);
    step();
    check("t1_done_pend", pending, 0);
    check("t1_done_active", active, 0);

    // Two edges 0x28: priority gives 3 then 5
    src = 8'h28; step(); src = '0;
    check("t2_pend", pending, 8'h28);
    step();
    check("t2_id_a", claim_id, 3);
    claim_once();
    check("t2_pend_a", pending, 8'h20);
    complete_once(3'd3);
    step();
    check("t2_irq_b", irq, 1);
    check("t2_id_b", claim_id, 5);
    claim_once();
    complete_once(3'd5);
    step();
    check("t2_pend_end", pending, 0);
    check("t2_irq_end", irq, 0);

    // Level source 2
    cfg_edge = 8'hFB;
    src = 8'h04; step();
    check("t3_pend", pending, 8'h04);
    step();
    check("t3_id", claim_id, 2);
    claim_once();
    check("t3_claim_pend", pending, 8'h04);
    check("t3_claim_irq", irq, 0);
    complete_once(3'd2);
    check("t3_c1_irq", irq, 0);
    step();
    check("t3_c2_irq", irq, 1);
    check("t3_c2_id", claim_id, 2);
    src = '0; step();
    check("t3_drop_pend", pending, 0);
    step();
    check("t3_drop_irq", irq, 0);
    check("t3_drop_active", active, 0);
    cfg_edge = 8'hFF;
    step();

    // Masked source 1
    cfg_en = 8'h00;
    src = 8'h02; step(); src = '0;
    check("t4_pend", pending, 8'h02);
    step(); step();
    check("t4_masked_irq", irq, 0);
    check("t4_masked_ready", claim_ready, 0);
    cfg_en = 8'h02;
    step(); step();
    check("t4_en_irq", irq, 1);
    check("t4_en_id", claim_id, 1);
    claim_once();
    complete_once(3'd1);
    cfg_en = 8'hFF;
    step();

    // Holdoff H = 5 with mismatched complete and edge during holdoff
    cfg_holdoff = 16'd5;
    src = 8'h01; step(); src = '0;
    step();
    check("t5_id", claim_id, 0);
    claim_once();
    complete_once(3'd3);
    check("t5_mis_active", active, 1);
    check("t5_mis_irq", irq, 0);
    complete_once(3'd0);
    check("t5_c1_irq", irq, 0);
    src = 8'h40; step(); src = '0;
    check("t5_c2_irq", irq, 0);
    check("t5_c2_pend", pending, 8'h40);
    for (int k = 3; k <= 6; k++) begin
      step();
      check($sformatf("t5_c%0d_irq", k), irq, 0);
    end
    step();
    check("t5_c7_irq", irq, 1);
    check("t5_c7_id", claim_id, 6);

    // Reset while CLAIMED with another source pending
    src = 8'h80;
    claim_once();
    src = '0;
    check("t6_pre_pend", pending, 8'h80);
    check("t6_pre_active", active, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_irq", irq, 0);
    check("t6_ready", claim_ready, 0);
    check("t6_id", claim_id, 0);
    check("t6_pend", pending, 0);
    check("t6_active", active, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
